// File: rtl/frame_stream_pkg.sv
// rtl/frame_stream_pkg.sv - shared types, colour coefficients and channel expand helper
package frame_stream_pkg;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_GRAY   = 3'd1,
    MODE_PINK   = 3'd2,
    MODE_INVERT = 3'd3,
    MODE_THRESH = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } state_e;

  localparam int GRAY_R = 77;
  localparam int GRAY_G = 150;
  localparam int GRAY_B = 29;
  localparam int PINK_R = 120;
  localparam int PINK_G = 60;
  localparam int PINK_B = 50;

  localparam int CH_MAX_W = 16;
  localparam int CH_IDX_W = 4;

  // Replicates an in_w-bit channel MSB-first into out_w bits; leftover low bits stay zero.
  function automatic logic [CH_MAX_W-1:0] expand_ch(input logic [CH_MAX_W-1:0] val,
                                                     input int in_w, input int out_w);
    logic [CH_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < CH_MAX_W; i++) begin
      if (i < out_w && i < (out_w / in_w) * in_w)
        res[CH_IDX_W'(out_w - 1 - i)] = val[CH_IDX_W'(in_w - 1 - (i % in_w))];
    end
    return res;
  endfunction

endpackage

// File: rtl/pixel_colour_xform.sv
// rtl/pixel_colour_xform.sv - registered colour transform stage between frame-buffer read and output FIFO
module pixel_colour_xform
  import frame_stream_pkg::*;
#(
  parameter int IN_CH_W  = 4,
  parameter int OUT_CH_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic [2:0]            i_mode,
  input  logic [3*IN_CH_W-1:0]  i_data,
  output logic                  o_valid,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [3*OUT_CH_W-1:0] o_data
);

  localparam int SUM_W = OUT_CH_W + 8;

  logic [OUT_CH_W-1:0]   w_r, w_g, w_b, w_y, w_p;
  logic [SUM_W-1:0]      w_gray_sum, w_pink_sum;
  logic [3*OUT_CH_W-1:0] w_data;

  assign w_r = OUT_CH_W'(expand_ch(CH_MAX_W'(i_data[3*IN_CH_W-1 -: IN_CH_W]), IN_CH_W, OUT_CH_W));
  assign w_g = OUT_CH_W'(expand_ch(CH_MAX_W'(i_data[2*IN_CH_W-1 -: IN_CH_W]), IN_CH_W, OUT_CH_W));
  assign w_b = OUT_CH_W'(expand_ch(CH_MAX_W'(i_data[IN_CH_W-1 -: IN_CH_W]), IN_CH_W, OUT_CH_W));

  assign w_gray_sum = SUM_W'(GRAY_R) * SUM_W'(w_r) + SUM_W'(GRAY_G) * SUM_W'(w_g)
                    + SUM_W'(GRAY_B) * SUM_W'(w_b);
  assign w_pink_sum = SUM_W'(PINK_R) * SUM_W'(w_r) + SUM_W'(PINK_G) * SUM_W'(w_g)
                    + SUM_W'(PINK_B) * SUM_W'(w_b);
  assign w_y = w_gray_sum[OUT_CH_W+7:8];
  assign w_p = w_pink_sum[OUT_CH_W+7:8];

  always_comb begin
    w_data = {w_r, w_g, w_b};
    case (i_mode)
      MODE_GRAY:   w_data = {w_y, w_y, w_y};
      MODE_PINK:   w_data = {w_p, w_p >> 2, w_p >> 1};
      MODE_INVERT: w_data = {~w_r, ~w_g, ~w_b};
      MODE_THRESH: w_data = {(3*OUT_CH_W){w_y[OUT_CH_W-1]}};
      default:     w_data = {w_r, w_g, w_b};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= i_valid & ~i_flush;
      if (i_valid) begin
        o_sop  <= i_sop;
        o_eop  <= i_eop;
        o_data <= w_data;
      end
    end
  end

endmodule

// File: rtl/frame_stream_source.sv
// rtl/frame_stream_source.sv - frame-buffer walker emitting one credit-limited video packet per frame
module frame_stream_source
  import frame_stream_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int IN_CH_W    = 4,
  parameter int OUT_CH_W   = 10,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           frame_restart,
  input  logic [2:0]                     mode,
  output logic [$clog2(H_RES*V_RES)-1:0] rd_addr,
  input  logic [3*IN_CH_W-1:0]           rd_data,
  output logic [3*OUT_CH_W-1:0]          src_data,
  output logic                           src_valid,
  input  logic                           src_ready,
  output logic                           src_sop,
  output logic                           src_eop,
  output logic [15:0]                    frame_count
);

  localparam int NPIX = H_RES * V_RES;
  localparam int AW   = $clog2(NPIX);
  localparam int DW   = 3 * OUT_CH_W;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int IFW  = $clog2(RD_LAT + FIFO_DEPTH + 2);

  state_e                  r_state, w_next_state;
  logic [AW-1:0]           r_addr;
  logic [2:0]              r_mode_latched;
  logic [RD_LAT-1:0]       r_vpipe, r_sop_pipe, r_eop_pipe;
  logic [RD_LAT-1:0][2:0]  r_mode_pipe;
  logic [DW+1:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_fifo_cnt;
  logic [15:0]             r_frame_count;

  logic                    w_issue, w_flush, w_credit, w_pop, w_last, w_addr_zero;
  logic [2:0]              w_issue_mode;
  logic [IFW-1:0]          w_pipe_cnt, w_in_flight;
  logic                    w_x_valid, w_x_sop, w_x_eop;
  logic [DW-1:0]           w_x_data;
  logic [DW+1:0]           w_head;

  assign w_addr_zero  = (r_addr == '0);
  assign w_last       = (r_addr == AW'(NPIX - 1));
  assign w_issue_mode = w_addr_zero ? mode : r_mode_latched;
  assign w_pop        = src_valid & src_ready;

  always_comb begin
    w_pipe_cnt = '0;
    for (int i = 0; i < RD_LAT; i++)
      w_pipe_cnt = w_pipe_cnt + IFW'(r_vpipe[i]);
  end

  // A beat leaving this cycle frees its slot, which keeps one read per clock at RD_LAT+2 entries.
  assign w_in_flight = w_pipe_cnt + IFW'(w_x_valid) + IFW'(r_fifo_cnt);
  assign w_credit    = (w_in_flight < IFW'(FIFO_DEPTH)) || w_pop;

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (frame_restart) begin
          w_flush      = 1'b1;
          w_next_state = ST_FLUSH;
        end else if (!enable && w_addr_zero) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_issue = w_credit;
          if (w_credit && w_last && !enable) w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_restart) begin
          w_flush      = 1'b1;
          w_next_state = ST_FLUSH;
        end else if (w_in_flight == '0) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_next_state = enable ? ST_RUN : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_mode_latched <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_flush || (r_state == ST_IDLE && frame_restart)) begin
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= w_last ? '0 : r_addr + 1'b1;
        if (w_addr_zero) r_mode_latched <= mode;
      end
    end
  end

  // Valid/tag shift register mirrors the frame-buffer read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vpipe     <= '0;
      r_sop_pipe  <= '0;
      r_eop_pipe  <= '0;
      r_mode_pipe <= '0;
    end else if (w_flush) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0]     <= w_issue;
      r_sop_pipe[0]  <= w_addr_zero;
      r_eop_pipe[0]  <= w_last;
      r_mode_pipe[0] <= w_issue_mode;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vpipe[i]     <= r_vpipe[i-1];
        r_sop_pipe[i]  <= r_sop_pipe[i-1];
        r_eop_pipe[i]  <= r_eop_pipe[i-1];
        r_mode_pipe[i] <= r_mode_pipe[i-1];
      end
    end
  end

  pixel_colour_xform #(
    .IN_CH_W  (IN_CH_W),
    .OUT_CH_W (OUT_CH_W)
  ) u_xform (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_valid (r_vpipe[RD_LAT-1]),
    .i_sop   (r_sop_pipe[RD_LAT-1]),
    .i_eop   (r_eop_pipe[RD_LAT-1]),
    .i_mode  (r_mode_pipe[RD_LAT-1]),
    .i_data  (rd_data),
    .o_valid (w_x_valid),
    .o_sop   (w_x_sop),
    .o_eop   (w_x_eop),
    .o_data  (w_x_data)
  );

  always_ff @(posedge clk) begin
    if (w_x_valid && !w_flush) r_mem[r_wr_ptr] <= {w_x_sop, w_x_eop, w_x_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_x_valid) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_fifo_cnt <= r_fifo_cnt + CW'(w_x_valid) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_frame_count <= '0;
    else if (w_pop && src_eop) r_frame_count <= r_frame_count + 16'd1;
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign src_valid   = (r_fifo_cnt != '0);
  assign src_data    = src_valid ? w_head[DW-1:0] : '0;
  assign src_sop     = src_valid & w_head[DW+1];
  assign src_eop     = src_valid & w_head[DW];
  assign rd_addr     = r_addr;
  assign frame_count = r_frame_count;

endmodule
